uart_mmio_bridge: RTL and testbench

UART_MMIO_BRIDGE -- requirements
Module: uart_mmio_bridge

---
 rtl/uart_pkg.sv | 19 +
 rtl/lowest_set_lane.sv | 24 ++
 rtl/uart_mmio_bridge.sv | 180 ++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART MMIO bridge: bus width, UART register map
// and the bridge FSM state encoding.
package uart_pkg;

   localparam int XLEN = 64;

   localparam logic [7:0] UART_THR = 8'h00;
   localparam logic [7:0] UART_RBR = 8'h00;
   localparam logic [7:0] UART_LSR = 8'h05;

   typedef enum logic [2:0] {
      IDLE,
      WR_LANE,
      RD_ISSUE,
      RD_CAPTURE,
      RESP
   } state_t;

endpackage

// File: rtl/lowest_set_lane.sv
// Priority encoder: returns the index of the lowest set bit of a byte-lane
// mask, plus a flag saying whether any bit was set at all.
module lowest_set_lane #(
   parameter int STRB_W = 8,
   parameter int LANE_W = (STRB_W > 1) ? $clog2(STRB_W) : 1
) (
   input  logic [STRB_W-1:0] i_mask,
   output logic [LANE_W-1:0] o_lane,
   output logic              o_valid
);

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      o_lane  = '0;
      o_valid = 1'b0;
      for (int i = STRB_W - 1; i >= 0; i--) begin
         if (i_mask[i]) begin
            o_lane  = LANE_W'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Bus-to-UART register bridge: splits one strobed bus access into a sequence
// of byte-wide UART register accesses, one per enabled lane, lowest lane first.
module uart_mmio_bridge #(
   parameter int XLEN   = uart_pkg::XLEN,
   parameter int STRB_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              uart_wen,
   output logic [7:0]        uart_waddr,
   output logic [7:0]        uart_wdata,
   output logic              uart_ren,
   output logic [7:0]        uart_raddr,
   input  logic [7:0]        uart_rdata
);

   import uart_pkg::*;

   localparam int LANE_W = (STRB_W > 1) ? $clog2(STRB_W) : 1;

   state_t              r_state;
   logic [4:0]          r_addr;
   logic [XLEN-1:0]     r_wdata;
   logic [XLEN-1:0]     r_acc;
   logic [STRB_W-1:0]   r_mask;
   logic [LANE_W-1:0]   r_lane;
   logic                r_respValid;
   logic [XLEN-1:0]     r_respRdata;
   logic                r_uartWen;
   logic [7:0]          r_uartWaddr;
   logic [7:0]          r_uartWdata;
   logic                r_uartRen;
   logic [7:0]          r_uartRaddr;

   logic                w_hs;
   logic                w_inIdle;
   logic [STRB_W-1:0]   w_encIn;
   logic [LANE_W-1:0]   w_lane;
   logic                w_laneValid;
   logic [STRB_W-1:0]   w_maskRest;
   logic [4:0]          w_addrSrc;
   logic [XLEN-1:0]     w_wdataSrc;
   logic [7:0]          w_offset;
   logic [7:0]          w_byte;
   logic [XLEN-1:0]     w_accNext;
   logic                w_unusedAddr;

   assign w_inIdle     = (r_state == IDLE);
   assign req_ready    = w_inIdle && !reset;
   assign w_hs         = req_valid && req_ready;
   assign w_unusedAddr = ^{req_addr[XLEN-1:8], req_addr[2:0]};

   // In IDLE the next lane comes straight from the request; afterwards r_mask
   // holds only the lanes still waiting behind the one currently on the port.
   assign w_encIn    = w_inIdle ? req_wstrb : r_mask;
   assign w_addrSrc  = w_inIdle ? req_addr[7:3] : r_addr;
   assign w_wdataSrc = w_inIdle ? req_wdata : r_wdata;
   assign w_maskRest = w_encIn & ~(STRB_W'(1) << w_lane);
   assign w_offset   = {w_addrSrc, 3'(w_lane)};
   assign w_byte     = w_wdataSrc[{w_lane, 3'b000} +: 8];

   lowest_set_lane #(
      .STRB_W (STRB_W),
      .LANE_W (LANE_W)
   ) u_lowestSetLane (
      .i_mask  (w_encIn),
      .o_lane  (w_lane),
      .o_valid (w_laneValid)
   );

   always_comb begin
      w_accNext = r_acc;
      w_accNext[{r_lane, 3'b000} +: 8] = uart_rdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_acc       <= '0;
         r_mask      <= '0;
         r_lane      <= '0;
         r_respValid <= 1'b0;
         r_respRdata <= '0;
         r_uartWen   <= 1'b0;
         r_uartWaddr <= '0;
         r_uartWdata <= '0;
         r_uartRen   <= 1'b0;
         r_uartRaddr <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hs) begin
                  r_addr  <= req_addr[7:3];
                  r_wdata <= req_wdata;
                  r_acc   <= '0;
                  r_lane  <= w_lane;
                  r_mask  <= w_maskRest;
                  if (!w_laneValid) begin
                     r_state     <= RESP;
                     r_respValid <= 1'b1;
                     r_respRdata <= '0;
                  end else if (req_wen) begin
                     r_state     <= WR_LANE;
                     r_uartWen   <= 1'b1;
                     r_uartWaddr <= w_offset;
                     r_uartWdata <= w_byte;
                  end else begin
                     r_state     <= RD_ISSUE;
                     r_uartRen   <= 1'b1;
                     r_uartRaddr <= w_offset;
                  end
               end
            end
            WR_LANE: begin
               if (w_laneValid) begin
                  r_lane      <= w_lane;
                  r_mask      <= w_maskRest;
                  r_uartWaddr <= w_offset;
                  r_uartWdata <= w_byte;
               end else begin
                  r_state     <= RESP;
                  r_uartWen   <= 1'b0;
                  r_uartWaddr <= '0;
                  r_uartWdata <= '0;
                  r_respValid <= 1'b1;
                  r_respRdata <= r_acc;
               end
            end
            RD_ISSUE: begin
               r_state     <= RD_CAPTURE;
               r_uartRen   <= 1'b0;
               r_uartRaddr <= '0;
            end
            // The UART answers one cycle after the read strobe, so capture here.
            RD_CAPTURE: begin
               r_acc <= w_accNext;
               if (w_laneValid) begin
                  r_state     <= RD_ISSUE;
                  r_lane      <= w_lane;
                  r_mask      <= w_maskRest;
                  r_uartRen   <= 1'b1;
                  r_uartRaddr <= w_offset;
               end else begin
                  r_state     <= RESP;
                  r_respValid <= 1'b1;
                  r_respRdata <= w_accNext;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_state     <= IDLE;
                  r_respValid <= 1'b0;
                  r_respRdata <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign resp_valid = r_respValid;
   assign resp_rdata = r_respRdata;
   assign uart_wen   = r_uartWen;
   assign uart_waddr = r_uartWaddr;
   assign uart_wdata = r_uartWdata;
   assign uart_ren   = r_uartRen;
   assign uart_raddr = r_uartRaddr;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for the UART MMIO bridge; a tiny UART model answers reads
// with (register offset + 0x5B) one cycle after the read strobe.
module tb_uart_mmio_bridge;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        uart_wen;
   logic [7:0]  uart_waddr;
   logic [7:0]  uart_wdata;
   logic        uart_ren;
   logic [7:0]  uart_raddr;
   logic [7:0]  uart_rdata;

   int total = 0;
   int bad   = 0;
   logic sawResp;

   uart_mmio_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .uart_wen   (uart_wen),
      .uart_waddr (uart_waddr),
      .uart_wdata (uart_wdata),
      .uart_ren   (uart_ren),
      .uart_raddr (uart_raddr),
      .uart_rdata (uart_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART register file model: read data appears the cycle after uart_ren.
   always @(posedge clk) begin
      uart_rdata <= uart_ren ? (uart_raddr + 8'h5B) : 8'h00;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives one request in cycle 0, checks it is accepted, and returns in cycle 1.
   task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wstrb);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = wstrb;
      checkOutput("hs_ready", {63'd0, req_ready}, 64'd1);
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_wstrb  = '0;
      resp_ready = 1'b1;
      sawResp    = 1'b0;

      // Reset held for three cycles
      tick();
      tick();
      checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd0);
      checkOutput("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      checkOutput("rst_resp_rdata", resp_rdata, 64'd0);
      checkOutput("rst_uart_en", {62'd0, uart_wen, uart_ren}, 64'd0);
      checkOutput("rst_uart_addr", {40'd0, uart_waddr, uart_wdata, uart_raddr}, 64'd0);
      tick();
      reset = 1'b0;
      tick();
      checkOutput("post_rst_ready", {63'd0, req_ready}, 64'd1);

      // Single-byte write
      applyStimulus(1'b1, 64'h0, 64'h41, 8'h01);
      checkOutput("w1_c1_ready", {63'd0, req_ready}, 64'd0);
      checkOutput("w1_c1_wen", {62'd0, uart_wen, uart_ren}, 64'd2);
      checkOutput("w1_c1_waddr", {56'd0, uart_waddr}, 64'h00);
      checkOutput("w1_c1_wdata", {56'd0, uart_wdata}, 64'h41);
      tick();
      checkOutput("w1_c2_wen", {62'd0, uart_wen, uart_ren}, 64'd0);
      checkOutput("w1_c2_resp_valid", {63'd0, resp_valid}, 64'd1);
      checkOutput("w1_c2_rdata", resp_rdata, 64'd0);
      tick();
      checkOutput("w1_c3_idle", {62'd0, resp_valid, req_ready}, 64'd1);

      // Single-byte read from lane 5
      applyStimulus(1'b0, 64'h0, 64'h0, 8'h20);
      checkOutput("r1_c1_en", {62'd0, uart_wen, uart_ren}, 64'd1);
      checkOutput("r1_c1_raddr", {56'd0, uart_raddr}, 64'h05);
      tick();
      checkOutput("r1_c2_en", {62'd0, uart_wen, uart_ren}, 64'd0);
      checkOutput("r1_c2_resp_valid", {63'd0, resp_valid}, 64'd0);
      tick();
      checkOutput("r1_c3_resp_valid", {63'd0, resp_valid}, 64'd1);
      checkOutput("r1_c3_rdata", resp_rdata, 64'h0000_6000_0000_0000);
      tick();

      // Sparse write; upper and low address bits must not leak into the offset
      applyStimulus(1'b1, 64'h105, 64'hAA00_0000_0000_0055, 8'h81);
      checkOutput("w2_c1_wen", {62'd0, uart_wen, uart_ren}, 64'd2);
      checkOutput("w2_c1_waddr", {56'd0, uart_waddr}, 64'h00);
      checkOutput("w2_c1_wdata", {56'd0, uart_wdata}, 64'h55);
      tick();
      checkOutput("w2_c2_wen", {62'd0, uart_wen, uart_ren}, 64'd2);
      checkOutput("w2_c2_waddr", {56'd0, uart_waddr}, 64'h07);
      checkOutput("w2_c2_wdata", {56'd0, uart_wdata}, 64'hAA);
      tick();
      checkOutput("w2_c3_wen", {62'd0, uart_wen, uart_ren}, 64'd0);
      checkOutput("w2_c3_resp_valid", {63'd0, resp_valid}, 64'd1);
      checkOutput("w2_c3_rdata", resp_rdata, 64'd0);
      tick();

      // Two-lane read at register block 3 (offsets 0x19, 0x1A)
      applyStimulus(1'b0, 64'h18, 64'h0, 8'h06);
      checkOutput("r2_c1_raddr", {55'd0, uart_ren, uart_raddr}, 64'h119);
      tick();
      checkOutput("r2_c2_en", {62'd0, uart_wen, uart_ren}, 64'd0);
      tick();
      checkOutput("r2_c3_raddr", {55'd0, uart_ren, uart_raddr}, 64'h11A);
      tick();
      checkOutput("r2_c4_resp_valid", {63'd0, resp_valid}, 64'd0);
      tick();
      checkOutput("r2_c5_resp_valid", {63'd0, resp_valid}, 64'd1);
      checkOutput("r2_c5_rdata", resp_rdata, 64'h0000_0000_0075_7400);
      tick();

      // Zero strobe with response backpressure and a competing request
      resp_ready = 1'b0;
      applyStimulus(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_wstrb = 8'hFF;
      for (int i = 1; i <= 4; i++) begin
         checkOutput("z_stall_resp", {61'd0, resp_valid, uart_wen, uart_ren}, 64'd4);
         checkOutput("z_stall_rdata", resp_rdata, 64'd0);
         checkOutput("z_stall_ready", {63'd0, req_ready}, 64'd0);
         if (i < 4) tick();
      end
      resp_ready = 1'b1;
      req_valid  = 1'b0;
      tick();
      checkOutput("z_release_idle", {62'd0, resp_valid, req_ready}, 64'd1);
      checkOutput("z_release_en", {62'd0, uart_wen, uart_ren}, 64'd0);

      // Reset in the middle of an eight-lane read
      applyStimulus(1'b0, 64'h0, 64'h0, 8'hFF);
      checkOutput("rr_c1_raddr", {55'd0, uart_ren, uart_raddr}, 64'h100);
      tick();
      checkOutput("rr_c2_en", {62'd0, uart_wen, uart_ren}, 64'd0);
      tick();
      checkOutput("rr_c3_raddr", {55'd0, uart_ren, uart_raddr}, 64'h101);
      tick();
      reset = 1'b1;
      #1;
      checkOutput("rr_rst_en", {62'd0, uart_wen, uart_ren}, 64'd0);
      checkOutput("rr_rst_resp", {63'd0, resp_valid}, 64'd0);
      checkOutput("rr_rst_ready", {63'd0, req_ready}, 64'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sawResp = sawResp | resp_valid | uart_ren;
         tick();
      end
      checkOutput("rr_no_resp", {63'd0, sawResp}, 64'd0);

      applyStimulus(1'b0, 64'h0, 64'h0, 8'h01);
      checkOutput("rn_c1_raddr", {55'd0, uart_ren, uart_raddr}, 64'h100);
      tick();
      tick();
      checkOutput("rn_c3_resp_valid", {63'd0, resp_valid}, 64'd1);
      checkOutput("rn_c3_rdata", resp_rdata, 64'h5B);
      tick();
      checkOutput("rn_c4_idle", {62'd0, resp_valid, req_ready}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
